int_to_float_pipe: RTL

INT_TO_FLOAT_PIPE -- requirements
Module: int_to_float_pipe

---
 rtl/int_to_float_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe: converts an IN_W-bit integer (two's complement or
// unsigned) into an IEEE-754 single-precision value through three register
// stages under valid/ready flow control. Stage 1 captures the sign and
// magnitude. Stage 2 finds the leading one and left-normalises the
// magnitude. Stage 3 rounds under the selected mode and packs the result.
// The edge that accepts a sample loads stage 1, so the result is visible
// three cycles after the cycle in which the sample was presented.
module int_to_float_pipe #(
    parameter int IN_W   = 16,
    parameter int SIGNED = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    input  logic [1:0]      in_rm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            out_inexact
);
    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;
    localparam int         PAD    = 32 - IN_W;

    logic            advance_s;

    logic            s1_valid_q;
    logic            s1_sign_q;
    logic [IN_W-1:0] s1_mag_q;
    logic [1:0]      s1_rm_q;
    logic            s1_sign_d;
    logic [IN_W-1:0] s1_mag_d;

    logic            s2_valid_q;
    logic            s2_sign_q;
    logic            s2_zero_q;
    logic [1:0]      s2_rm_q;
    logic [4:0]      s2_pos_q;
    logic [IN_W-1:0] s2_norm_q;
    logic            s2_zero_d;
    logic [4:0]      s2_pos_d;
    logic [IN_W-1:0] s2_norm_d;

    logic            out_valid_q;
    logic [31:0]     out_data_q;
    logic            out_inexact_q;
    logic [31:0]     out_data_d;
    logic            out_inexact_d;

    logic [30:0]     below_s;
    logic [22:0]     frac_s;
    logic            round_en_s;
    logic            guard_s;
    logic            sticky_s;
    logic            inc_s;
    logic [23:0]     frac_sum_s;
    logic            carry_s;
    logic [7:0]      exp_s;

    // The whole pipe moves together; it only freezes when a result is waiting.
    assign advance_s   = !out_valid_q || out_ready;
    assign in_ready    = advance_s;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_inexact = out_inexact_q;

    // Stage 1 comb: split sign and magnitude; negation in IN_W bits covers the most negative value.
    always_comb begin
        s1_sign_d = 1'b0;
        s1_mag_d  = in_data;
        if ((SIGNED != 0) && in_data[IN_W-1]) begin
            s1_sign_d = 1'b1;
            s1_mag_d  = ~in_data + {{(IN_W-1){1'b0}}, 1'b1};
        end else begin
            s1_sign_d = 1'b0;
            s1_mag_d  = in_data;
        end
    end

    // Stage 1 registers: capture the accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= {IN_W{1'b0}};
            s1_rm_q    <= 2'b00;
        end else if (advance_s) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_rm_q    <= in_rm;
        end
    end

    // Stage 2 comb: leading-one search (highest set bit wins) and left-normalisation.
    always_comb begin
        s2_pos_d = 5'd0;
        for (int i = 0; i < IN_W; i++) begin
            if (s1_mag_q[i]) begin
                s2_pos_d = 5'(i);
            end else begin
                s2_pos_d = s2_pos_d;
            end
        end
        s2_zero_d = (s1_mag_q == {IN_W{1'b0}});
        s2_norm_d = s1_mag_q << (5'(IN_W - 1) - s2_pos_d);
    end

    // Stage 2 registers: leading-one position, normalised magnitude and zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_rm_q    <= 2'b00;
            s2_pos_q   <= 5'd0;
            s2_norm_q  <= {IN_W{1'b0}};
        end else if (advance_s) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= s2_zero_d;
            s2_rm_q    <= s1_rm_q;
            s2_pos_q   <= s2_pos_d;
            s2_norm_q  <= s2_norm_d;
        end
    end

    // Stage 3 comb: round the 23 bits below the leading one and pack sign/exponent/fraction.
    always_comb begin
        below_s    = 31'(32'(s2_norm_q) << PAD);
        frac_s     = below_s[30:8];
        round_en_s = (s2_pos_q > 5'd23);
        if (round_en_s) begin
            guard_s  = below_s[7];
            sticky_s = |below_s[6:0];
        end else begin
            guard_s  = 1'b0;
            sticky_s = 1'b0;
        end
        case (s2_rm_q)
            RM_RNE:  inc_s = guard_s & (sticky_s | frac_s[0]);
            RM_RTZ:  inc_s = 1'b0;
            RM_RUP:  inc_s = (guard_s | sticky_s) & ~s2_sign_q;
            RM_RDN:  inc_s = (guard_s | sticky_s) & s2_sign_q;
            default: inc_s = 1'b0;
        endcase
        frac_sum_s = {1'b0, frac_s} + {23'd0, inc_s};
        carry_s    = frac_sum_s[23];
        exp_s      = {3'd0, s2_pos_q} + 8'd127 + {7'd0, carry_s};
        if (s2_zero_q) begin
            out_data_d    = 32'd0;
            out_inexact_d = 1'b0;
        end else begin
            out_data_d    = {s2_sign_q, exp_s, (carry_s ? 23'd0 : frac_sum_s[22:0])};
            out_inexact_d = guard_s | sticky_s;
        end
    end

    // Stage 3 registers: the output register, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= 32'd0;
            out_inexact_q <= 1'b0;
        end else if (advance_s) begin
            out_valid_q   <= s2_valid_q;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
        end
    end

endmodule
